// File: rtl/irq_encoder_8to3.sv
// rtl/irq_encoder_8to3.sv - registered priority encoder with pending store and valid/ready output
// Captures request pulses into a pending set and offers them lowest-index-first.
module irq_encoder_8to3 #(
  parameter int W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [(1<<W)-1:0]   req,
  output logic [W-1:0]        out_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(1<<W)-1:0]   pending,
  output logic                overflow
);

  localparam int N = 1 << W;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state;
  logic           load;
  logic [N-1:0]   lowest;
  logic [N-1:0]   claim;
  logic [W-1:0]   lowest_idx;

  // Isolate the lowest set bit; the loop runs high-to-low so the last hit wins.
  assign lowest = pending & (~pending + {{(N-1){1'b0}}, 1'b1});

  always_comb begin
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) lowest_idx = i[W-1:0];
    end
  end

  // A new index may be loaded from IDLE or on the accepting edge in HOLD.
  always_comb begin
    load = 1'b0;
    if (en && (pending != '0)) begin
      if (state == IDLE) load = 1'b1;
      else if (out_ready) load = 1'b1;
    end
  end

  assign claim = load ? lowest : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      state     <= IDLE;
    end else begin
      pending  <= (pending & ~claim) | req;
      overflow <= |(req & pending & ~claim);
      case (state)
        IDLE: begin
          if (load) begin
            out_idx   <= lowest_idx;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (load) begin
              out_idx <= lowest_idx;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
